alu_serial_seq: RTL and testbench

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

---
 rtl/alu_serial_seq.sv | 143 ++++++++++++++
 tb/tb_alu_serial_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer.
// Streams two W-bit operands LSB first through an external 1-bit ALU
// (whose carry/borrow input is tied to 0) and rebuilds the ripple chain
// locally with flop r_c, giving add/sub/OR/AND on W-bit words in W cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; ALU drive lines held at 0
// RUN   | W cycles, one operand bit per cycle, LSB first
// DONE  | one cycle, done=1, result/carry_out/zero just loaded
module alu_serial_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero,
  output logic [2:0]   alu_codigo,
  output logic         alu_op1,
  output logic         alu_op2,
  input  logic         alu_rta,
  input  logic         alu_bcout
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam int         CW     = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_c;

  logic          w_bit;
  logic          w_c_next;
  logic [W-1:0]  w_acc_next;
  logic          w_run;

  // ALU drive lines are live only in RUN so the shared ALU sees 0 otherwise
  assign w_run      = (r_state == RUN);
  assign alu_codigo = w_run ? r_op  : 3'b000;
  assign alu_op1    = w_run ? r_sa[0] : 1'b0;
  assign alu_op2    = w_run ? r_sb[0] : 1'b0;

  // Fold the local chain bit into the ALU's cin=0 answer (add/sub only)
  always_comb begin
    w_bit    = alu_rta;
    w_c_next = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_bit    = alu_rta ^ r_c;
        w_c_next = alu_bcout | (alu_rta & r_c);
      end
      OP_SUB: begin
        w_bit    = alu_rta ^ r_c;
        w_c_next = alu_bcout | (~alu_rta & r_c);
      end
      default: begin
        w_bit    = alu_rta;
        w_c_next = 1'b0;
      end
    endcase
  end

  assign w_acc_next = {w_bit, r_acc[W-1:1]};

  // Sequencer: latch operands, shift W bits through the ALU, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= 3'b000;
      r_sa      <= '0;
      r_sb      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_c       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_sa    <= a;
            r_sb    <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_c   <= w_c_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            // Outputs change only here so they stay stable through RUN
            result    <= w_acc_next;
            carry_out <= w_c_next;
            zero      <= (w_acc_next == '0);
            done      <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (W=8) with a behavioural 1-bit ALU.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic [2:0]   alu_codigo;
  logic         alu_op1;
  logic         alu_op2;
  logic         alu_rta;
  logic         alu_bcout;

  int n_checks = 0;
  int n_fails  = 0;

  alu_serial_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .zero(zero), .alu_codigo(alu_codigo), .alu_op1(alu_op1),
    .alu_op2(alu_op2), .alu_rta(alu_rta), .alu_bcout(alu_bcout)
  );

  always #5 clk = ~clk;

  // 1-bit ALU with carry/borrow input fixed at 0
  always_comb begin
    alu_rta   = 1'b0;
    alu_bcout = 1'b0;
    case (alu_codigo)
      3'b001: begin alu_rta = alu_op1 ^ alu_op2; alu_bcout = alu_op1 & alu_op2;  end
      3'b010: begin alu_rta = alu_op1 ^ alu_op2; alu_bcout = ~alu_op1 & alu_op2; end
      3'b100: alu_rta = alu_op1 | alu_op2;
      3'b101: alu_rta = alu_op1 & alu_op2;
      default: begin alu_rta = 1'b0; alu_bcout = 1'b0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one operation from IDLE; optionally poke start again at RUN
  // cycle poke. Checks latency, stability during RUN, and final outputs.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ec, input logic ez,
                        input int poke);
    logic [W-1:0] held_res;
    logic         held_c;
    int           lat;
    held_res = result;
    held_c   = carry_out;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy run0"}, busy, 1'b1);
    chk({tag, " codigo run0"}, alu_codigo, o);
    chk({tag, " op1 run0"}, alu_op1, x[0]);
    chk({tag, " op2 run0"}, alu_op2, y[0]);
    lat = 0;
    while (done !== 1'b1 && lat < 3 * W) begin
      if (lat == 2) begin
        chk({tag, " result held in run"}, result, held_res);
        chk({tag, " carry held in run"}, carry_out, held_c);
      end
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        start = 1'b1; op = 3'b010; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    // done appears after edge k+W, so it is captured at edge k+W+1
    chk({tag, " done latency"}, lat + 1, W + 1);
    chk({tag, " result"}, result, er);
    chk({tag, " carry_out"}, carry_out, ec);
    chk({tag, " zero"}, zero, ez);
    chk({tag, " busy in done"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, " done one cycle"}, done, 1'b0);
    chk({tag, " busy idle"}, busy, 1'b0);
    chk({tag, " codigo idle"}, alu_codigo, 3'b000);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst result", result, 8'h00);
    chk("rst carry", carry_out, 1'b0);
    chk("rst zero", zero, 1'b0);
    chk("rst codigo", alu_codigo, 3'b000);
    chk("rst op1", alu_op1, 1'b0);

    run_op("add FF+01", 3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, -1);
    run_op("sub 05-07", 3'b010, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, -1);
    run_op("sub 07-05", 3'b010, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, -1);
    run_op("or A0|0A",  3'b100, 8'hA0, 8'h0A, 8'hAA, 1'b0, 1'b0, -1);
    run_op("and F0&3C", 3'b101, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, -1);
    run_op("op111",     3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, -1);
    run_op("add 12+34 poke", 3'b001, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);

    // Abort an add at RUN cycle 4 with reset
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 8'h0F; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, 8'h00);
    chk("abort carry", carry_out, 1'b0);
    chk("abort zero", zero, 1'b0);
    pulses = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("abort no done pulse", pulses, 0);
    chk("abort result stays", result, 8'h00);

    run_op("add after abort", 3'b001, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
